pipe_hazard_ctrl: RTL and testbench

// Interlock and flush controller for the 5-stage IF/ID/EX/MEM/WB datapath.
// - Tracks register and flag writes still in flight in a 3-entry scoreboard covering EX, MEM and WB.
// - Stalls IF/ID on RAW hazards, since the datapath has no forwarding.
// - Inserts bubbles into PR2.
// - Squashes the IF slot when ID resolves a taken jump, branch, call or return.
// - Drives the PC, PR1 and PR2 load/flush controls.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 76 +++++++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the IF/ID/EX/MEM/WB interlock controller.
//   REG_ID_LEN  : register id width (8-entry register file)
//   SB_DEPTH    : scoreboard entries, one per stage after ID (EX, MEM, WB)
//   sb_entry_t  : one in-flight write {valid, wr_en, wr_reg, set_flags}
//   pipe_state_t: controller FSM state
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_ID_LEN = 3;
  localparam int SB_DEPTH   = 3;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ID_LEN-1:0] wr_reg;
    logic                  set_flags;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the ID-stage decode information going into the hazard controller
// and the pipeline load/flush controls coming back out of it.
//   master : drives the id_* decode fields, observes the controls
//   slave  : the controller (reads id_*, drives controls and status)
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_LEN = 16
);
  import pipe_pkg::*;

  // ID-stage decode
  logic                  id_valid;
  logic [REG_ID_LEN-1:0] id_rs1;
  logic [REG_ID_LEN-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  id_use_flags;
  logic                  id_wr_en;
  logic [REG_ID_LEN-1:0] id_wr_reg;
  logic                  id_set_flags;
  logic                  id_redirect;

  // Pipeline controls and status
  logic                  pc_ld;
  logic                  pr1_ld;
  logic                  pr1_flush;
  logic                  pr2_bubble;
  logic                  pc_sel_redir;
  logic [1:0]            state_o;
  logic [CNT_LEN-1:0]    stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_use_flags,
           id_wr_en, id_wr_reg, id_set_flags, id_redirect,
    input  pc_ld, pr1_ld, pr1_flush, pr2_bubble, pc_sel_redir, state_o,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_use_flags,
           id_wr_en, id_wr_reg, id_set_flags, id_redirect,
    output pc_ld, pr1_ld, pr1_flush, pr2_bubble, pc_sel_redir, state_o,
           stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
// Shift chain of in-flight writes (entry 0 = EX, 1 = MEM, 2 = WB) plus the
// combinational lookups the interlock needs.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the chain)
//   i_issue       : the ID instruction advances into EX this edge
//   i_entry       : its scoreboard entry
//   i_rs1, i_rs2  : ID source registers to look up
//   o_match_rs1/2 : a pending write targets that register
//   o_flag_busy   : the EX entry will update the flags
// ---------------------------------------------------------------------------
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int RF_BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_issue,
  input  sb_entry_t             i_entry,
  input  logic [REG_ID_LEN-1:0] i_rs1,
  input  logic [REG_ID_LEN-1:0] i_rs2,
  output logic                  o_match_rs1,
  output logic                  o_match_rs2,
  output logic                  o_flag_busy
);

  // With a write-through register file the WB entry is already readable,
  // so only EX and MEM are searched.
  localparam int NCHK = (RF_BYPASS != 0) ? SB_DEPTH - 1 : SB_DEPTH;

  sb_entry_t           r_sb [SB_DEPTH];
  logic [SB_DEPTH-1:0] w_hit_rs1;
  logic [SB_DEPTH-1:0] w_hit_rs2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        r_sb[k] <= '0;
      end
    end else begin
      r_sb[0] <= i_issue ? i_entry : '0;
      for (int k = 1; k < SB_DEPTH; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      if (gi < NCHK) begin : g_chk
        assign w_hit_rs1[gi] = r_sb[gi].valid & r_sb[gi].wr_en &
                               (r_sb[gi].wr_reg == i_rs1);
        assign w_hit_rs2[gi] = r_sb[gi].valid & r_sb[gi].wr_en &
                               (r_sb[gi].wr_reg == i_rs2);
      end else begin : g_skip
        assign w_hit_rs1[gi] = 1'b0;
        assign w_hit_rs2[gi] = 1'b0;
      end
    end
  endgenerate

  assign o_match_rs1 = |w_hit_rs1;
  assign o_match_rs2 = |w_hit_rs2;

  // Flags are written as the producer leaves EX, so only entry 0 matters.
  assign o_flag_busy = r_sb[0].valid & r_sb[0].set_flags;

  // Flag bits beyond EX, and the whole WB entry when bypassing, are carried
  // along the chain but never consulted.
  logic w_unused_bits;
  assign w_unused_bits = ^{r_sb[1].set_flags, r_sb[2]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Interlock and flush controller for a 5-stage pipeline without forwarding.
// Stalls IF/ID on RAW hazards against writes still in EX/MEM/WB, bubbles
// PR2 while stalled, and squashes the IF slot after a taken redirect
// resolved in ID.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pipe_hazard_ctrl_if.slave -- ID decode in, PC/PR1/PR2 controls,
//          FSM state and saturating stall counter out
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RF_BYPASS = 0,
  parameter int CNT_LEN   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_hazard_ctrl_if.slave        bus
);

  pipe_state_t        r_state;
  pipe_state_t        w_state_next;
  logic [CNT_LEN-1:0] r_stall_cnt;

  logic      w_in_flush;
  logic      w_match_rs1;
  logic      w_match_rs2;
  logic      w_flag_busy;
  logic      w_hazard;
  logic      w_redirect;
  logic      w_issue;
  sb_entry_t w_entry;

  logic w_pc_ld;
  logic w_pr1_ld;
  logic w_pr1_flush;
  logic w_pr2_bubble;
  logic w_pc_sel_redir;

  // The slot in ID during FLUSH was fetched down the wrong path: it never
  // issues, never stalls and cannot redirect.
  assign w_in_flush = (r_state == FLUSH);

  assign w_hazard = bus.id_valid & ~w_in_flush &
                    ((bus.id_use_rs1   & w_match_rs1) |
                     (bus.id_use_rs2   & w_match_rs2) |
                     (bus.id_use_flags & w_flag_busy));

  assign w_redirect = bus.id_redirect & bus.id_valid & ~w_hazard & ~w_in_flush;
  assign w_issue    = bus.id_valid & ~w_hazard & ~w_in_flush;

  assign w_entry = '{valid:     1'b1,
                     wr_en:     bus.id_wr_en,
                     wr_reg:    bus.id_wr_reg,
                     set_flags: bus.id_set_flags};

  pipe_scoreboard #(
    .RF_BYPASS (RF_BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_issue     (w_issue),
    .i_entry     (w_entry),
    .i_rs1       (bus.id_rs1),
    .i_rs2       (bus.id_rs2),
    .o_match_rs1 (w_match_rs1),
    .o_match_rs2 (w_match_rs2),
    .o_flag_busy (w_flag_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and control decode. A hazard outranks a redirect; the
  // redirect is taken once the operands it depends on have cleared.
  always_comb begin
    w_state_next   = r_state;
    w_pc_ld        = 1'b1;
    w_pr1_ld       = 1'b1;
    w_pr1_flush    = 1'b0;
    w_pr2_bubble   = 1'b0;
    w_pc_sel_redir = 1'b0;
    case (r_state)
      FLUSH: begin
        w_pr2_bubble = 1'b1;
        w_state_next = RUN;
      end
      RUN, STALL: begin
        if (w_hazard) begin
          w_pc_ld      = 1'b0;
          w_pr1_ld     = 1'b0;
          w_pr2_bubble = 1'b1;
          w_state_next = STALL;
        end else if (w_redirect) begin
          w_pc_sel_redir = 1'b1;
          w_pr1_flush    = 1'b1;
          w_state_next   = FLUSH;
        end else begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != {CNT_LEN{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.pc_ld        = w_pc_ld;
  assign bus.pr1_ld       = w_pr1_ld;
  assign bus.pr1_flush    = w_pr1_flush;
  assign bus.pr2_bubble   = w_pr2_bubble;
  assign bus.pc_sel_redir = w_pc_sel_redir;
  assign bus.state_o      = r_state;
  assign bus.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Drives two controllers (register file without and with write-through)
// with identical ID streams. The reference tracks, per register and for the
// flags, the cycle from which a pending write becomes readable, and derives
// stalls, redirects and the FSM from that.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CL   = 5;
  localparam int CMAX = (1 << CL) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  pipe_hazard_ctrl_if #(.CNT_LEN(CL)) bus0 ();
  pipe_hazard_ctrl_if #(.CNT_LEN(CL)) bus1 ();

  pipe_hazard_ctrl #(.RF_BYPASS(0), .CNT_LEN(CL)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  pipe_hazard_ctrl #(.RF_BYPASS(1), .CNT_LEN(CL)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic       u1;
    logic [2:0] rs1;
    logic       u2;
    logic [2:0] rs2;
    logic       uf;
    logic       we;
    logic [2:0] wr;
    logic       sf;
    logic       redir;
  } stim_t;

  // Reference state: first cycle each register / the flags may be read.
  int unsigned cyc;
  int unsigned rdy   [2][8];
  int unsigned frdy  [2];
  int          mstate[2];   // 0 run, 1 stall, 2 flush
  int          mcnt  [2];

  function automatic stim_t mk(input logic v, input logic u1, input logic [2:0] r1,
                               input logic u2, input logic [2:0] r2, input logic uf,
                               input logic we, input logic [2:0] wr, input logic sf,
                               input logic rd, input logic rs);
    stim_t s;
    s = '{rst: rs, valid: v, u1: u1, rs1: r1, u2: u2, rs2: r2, uf: uf,
          we: we, wr: wr, sf: sf, redir: rd};
    return s;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 8; r++) rdy[b][r] = 0;
      frdy[b]   = 0;
      mstate[b] = 0;
      mcnt[b]   = 0;
    end
  endtask

  task automatic apply(input stim_t s);
    rst               = s.rst;
    bus0.id_valid     = s.valid;  bus1.id_valid     = s.valid;
    bus0.id_use_rs1   = s.u1;     bus1.id_use_rs1   = s.u1;
    bus0.id_rs1       = s.rs1;    bus1.id_rs1       = s.rs1;
    bus0.id_use_rs2   = s.u2;     bus1.id_use_rs2   = s.u2;
    bus0.id_rs2       = s.rs2;    bus1.id_rs2       = s.rs2;
    bus0.id_use_flags = s.uf;     bus1.id_use_flags = s.uf;
    bus0.id_wr_en     = s.we;     bus1.id_wr_en     = s.we;
    bus0.id_wr_reg    = s.wr;     bus1.id_wr_reg    = s.wr;
    bus0.id_set_flags = s.sf;     bus1.id_set_flags = s.sf;
    bus0.id_redirect  = s.redir;  bus1.id_redirect  = s.redir;
  endtask

  // {pc_ld, pr1_ld, pr1_flush, pr2_bubble, pc_sel_redir, state[1:0], cnt[4:0]}
  function automatic logic [31:0] obs(input int b);
    if (b == 0)
      return {20'b0, bus0.pc_ld, bus0.pr1_ld, bus0.pr1_flush, bus0.pr2_bubble,
              bus0.pc_sel_redir, bus0.state_o, bus0.stall_cnt};
    else
      return {20'b0, bus1.pc_ld, bus1.pr1_ld, bus1.pr1_flush, bus1.pr2_bubble,
              bus1.pc_sel_redir, bus1.state_o, bus1.stall_cnt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // One clock of stimulus: check outputs mid-cycle, then advance the model.
  task automatic step(input stim_t s);
    logic haz [2];
    logic red [2];
    logic flushing;
    logic [4:0] ectl;
    apply(s);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      flushing = (mstate[b] == 2);
      haz[b] = s.valid && !flushing &&
               ((s.u1 && cyc < rdy[b][s.rs1]) ||
                (s.u2 && cyc < rdy[b][s.rs2]) ||
                (s.uf && cyc < frdy[b]));
      red[b] = s.redir && s.valid && !haz[b] && !flushing;
      if (flushing)    ectl = 5'b11010;
      else if (haz[b]) ectl = 5'b00010;
      else if (red[b]) ectl = 5'b11101;
      else             ectl = 5'b11000;
      chk($sformatf("dut%0d_cyc%0d", b, cyc), obs(b),
          {20'b0, ectl, 2'(mstate[b]), 5'(mcnt[b])});
    end
    @(posedge clk);
    if (s.rst) begin
      model_reset();
    end else begin
      for (int b = 0; b < 2; b++) begin
        flushing = (mstate[b] == 2);
        if (s.valid && !haz[b] && !flushing) begin
          // Issued now: EX next cycle, leaves WB three cycles later.
          if (s.we) rdy[b][s.wr] = cyc + ((b == 1) ? 3 : 4);
          if (s.sf) frdy[b] = cyc + 2;
        end
        if (haz[b] && mcnt[b] < CMAX) mcnt[b]++;
        if (flushing)    mstate[b] = 0;
        else if (haz[b]) mstate[b] = 1;
        else if (red[b]) mstate[b] = 2;
        else             mstate[b] = 0;
      end
    end
    cyc++;
    #1;
  endtask

  stim_t idle, s;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s = idle;
    s.rst = 1'b1;
    apply(s);
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    model_reset();
    chk("reset_dut0", obs(0), 32'h0000_0C00);
    chk("reset_dut1", obs(1), 32'h0000_0C00);

    // ADD r1 <= r4,r5 then SUB r2 <= r1,r6 held in ID until it issues
    step(mk(1, 1, 3'd4, 1, 3'd5, 0, 1, 3'd1, 0, 0, 0));
    repeat (4) step(mk(1, 1, 3'd1, 1, 3'd6, 0, 1, 3'd2, 0, 0, 0));
    chk("raw_stalls_nobypass", 32'(bus0.stall_cnt), 32'd3);
    chk("raw_stalls_bypass",   32'(bus1.stall_cnt), 32'd2);
    repeat (4) step(idle);

    // Flag setter then conditional branch; squashed slot writes r5
    step(mk(1, 1, 3'd3, 1, 3'd4, 0, 0, 3'd0, 1, 0, 0));
    repeat (2) step(mk(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd0, 0, 1, 0));
    step(mk(1, 1, 3'd2, 0, 3'd0, 0, 1, 3'd5, 0, 1, 0));
    step(mk(1, 1, 3'd5, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0));
    repeat (2) step(idle);

    // Unconditional jump, squashed slot, then a reader of the squashed dest
    step(mk(1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1, 0));
    step(mk(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd5, 0, 0, 0));
    step(mk(1, 1, 3'd5, 1, 3'd5, 0, 0, 3'd0, 0, 0, 0));
    repeat (3) step(idle);

    // Reset on the second stall cycle discards the pending write
    step(mk(1, 0, 3'd0, 0, 3'd0, 0, 1, 3'd3, 0, 0, 0));
    step(mk(1, 0, 3'd0, 1, 3'd3, 0, 1, 3'd6, 0, 0, 0));
    step(mk(1, 0, 3'd0, 1, 3'd3, 0, 1, 3'd6, 0, 0, 1));
    chk("rst_state_dut0", 32'(bus0.state_o),   32'd0);
    chk("rst_cnt_dut0",   32'(bus0.stall_cnt), 32'd0);
    chk("rst_cnt_dut1",   32'(bus1.stall_cnt), 32'd0);
    step(mk(1, 0, 3'd0, 1, 3'd3, 0, 1, 3'd6, 0, 0, 0));
    repeat (3) step(idle);

    // Self-dependent r1 <= r1 held in ID keeps stalling: counter saturates
    repeat (60) step(mk(1, 1, 3'd1, 0, 3'd0, 0, 1, 3'd1, 0, 0, 0));
    chk("sat_dut0", 32'(bus0.stall_cnt), 32'(CMAX));
    chk("sat_dut1", 32'(bus1.stall_cnt), 32'(CMAX));
    repeat (4) step(idle);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 39) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.u1    = 1'($urandom);
      s.rs1   = 3'($urandom);
      s.u2    = 1'($urandom);
      s.rs2   = 3'($urandom);
      s.uf    = ($urandom_range(0, 3) == 0);
      s.we    = 1'($urandom);
      s.wr    = 3'($urandom);
      s.sf    = ($urandom_range(0, 2) == 0);
      s.redir = ($urandom_range(0, 5) == 0);
      step(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
